// File: rtl/l1_l2_pkg.sv
// Shared widths and enumerations for the L1-to-L2 request arbiter.
package l1_l2_pkg;

   localparam int unsigned TAG_W   = 18;
   localparam int unsigned INDEX_W = 8;
   localparam int unsigned LINE_W  = 512;

   typedef enum logic [2:0] {
      IDLE,
      I_READ,
      D_WRITE,
      D_READ,
      DONE
   } arb_state_e;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; the priority bit moves to the loser side
// whenever a grant is taken.
module rr_arbiter2
   import l1_l2_pkg::*;
(
   input  logic    clk,
   input  logic    nrst,
   input  logic    req_i,
   input  logic    req_d,
   input  logic    update,
   output logic    grant_valid,
   output req_id_e grant
);

   req_id_e prio_q;

   always_comb begin
      grant_valid = req_i | req_d;
      grant       = (req_d && (!req_i || prio_q == REQ_D)) ? REQ_D : REQ_I;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         prio_q <= REQ_D;
      end else if (update && grant_valid) begin
         prio_q <= (grant == REQ_D) ? REQ_I : REQ_D;
      end
   end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the L2 request port between the L1 I and D caches; whole-transaction
// round-robin, D writeback issued before its refill under a single grant.
module l1_l2_arbiter #(
   parameter int unsigned TAG_W   = l1_l2_pkg::TAG_W,
   parameter int unsigned INDEX_W = l1_l2_pkg::INDEX_W,
   parameter int unsigned LINE_W  = l1_l2_pkg::LINE_W
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               read_I_arb,
   input  logic [TAG_W-1:0]   tag_I_arb,
   input  logic [INDEX_W-1:0] index_I_arb,
   output logic               ready_arb_I,
   input  logic               read_D_arb,
   input  logic               write_D_arb,
   input  logic [TAG_W-1:0]   tag_D_arb,
   input  logic [INDEX_W-1:0] index_D_arb,
   input  logic [TAG_W-1:0]   write_tag_D_arb,
   input  logic [INDEX_W-1:0] write_index_D_arb,
   input  logic [LINE_W-1:0]  write_data_D_arb,
   output logic               ready_arb_D,
   output logic [LINE_W-1:0]  read_data_arb_L1,
   output logic               read_arb_L2,
   output logic               write_arb_L2,
   output logic [TAG_W-1:0]   tag_arb_L2,
   output logic [INDEX_W-1:0] index_arb_L2,
   output logic [LINE_W-1:0]  write_data_arb_L2,
   input  logic [LINE_W-1:0]  read_data_L2_arb,
   input  logic               ready_L2_arb
);

   import l1_l2_pkg::*;

   arb_state_e         state_q, state_d;
   logic               rd_d, wr_d, rdy_i_d, rdy_d_d;
   logic [TAG_W-1:0]   tag_d;
   logic [INDEX_W-1:0] idx_d;
   logic [LINE_W-1:0]  wdata_d;

   // D refill address held for the read phase that follows a writeback
   logic               rd_flag_q, rd_flag_d;
   logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;
   logic [INDEX_W-1:0] rd_idx_q, rd_idx_d;

   logic    arb_update;
   logic    grant_valid;
   req_id_e grant;

   rr_arbiter2 u_rr (
      .clk         (clk),
      .nrst        (nrst),
      .req_i       (read_I_arb),
      .req_d       (read_D_arb | write_D_arb),
      .update      (arb_update),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign read_data_arb_L1 = read_data_L2_arb;

   always_comb begin
      state_d    = state_q;
      rd_d       = read_arb_L2;
      wr_d       = write_arb_L2;
      tag_d      = tag_arb_L2;
      idx_d      = index_arb_L2;
      wdata_d    = write_data_arb_L2;
      rdy_i_d    = 1'b0;
      rdy_d_d    = 1'b0;
      rd_flag_d  = rd_flag_q;
      rd_tag_d   = rd_tag_q;
      rd_idx_d   = rd_idx_q;
      arb_update = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               arb_update = 1'b1;
               if (grant == REQ_I) begin
                  state_d = I_READ;
                  rd_d    = 1'b1;
                  tag_d   = tag_I_arb;
                  idx_d   = index_I_arb;
               end else begin
                  rd_flag_d = read_D_arb;
                  rd_tag_d  = tag_D_arb;
                  rd_idx_d  = index_D_arb;
                  if (write_D_arb) begin
                     state_d = D_WRITE;
                     wr_d    = 1'b1;
                     tag_d   = write_tag_D_arb;
                     idx_d   = write_index_D_arb;
                     wdata_d = write_data_D_arb;
                  end else begin
                     state_d = D_READ;
                     rd_d    = 1'b1;
                     tag_d   = tag_D_arb;
                     idx_d   = index_D_arb;
                  end
               end
            end
         end
         I_READ: begin
            if (ready_L2_arb) begin
               rd_d    = 1'b0;
               rdy_i_d = 1'b1;
               state_d = DONE;
            end
         end
         D_WRITE: begin
            if (ready_L2_arb) begin
               wr_d = 1'b0;
               if (rd_flag_q) begin
                  rd_d    = 1'b1;
                  tag_d   = rd_tag_q;
                  idx_d   = rd_idx_q;
                  state_d = D_READ;
               end else begin
                  rdy_d_d = 1'b1;
                  state_d = DONE;
               end
            end
         end
         D_READ: begin
            if (ready_L2_arb) begin
               rd_d    = 1'b0;
               rdy_d_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q           <= IDLE;
         read_arb_L2       <= 1'b0;
         write_arb_L2      <= 1'b0;
         tag_arb_L2        <= '0;
         index_arb_L2      <= '0;
         write_data_arb_L2 <= '0;
         ready_arb_I       <= 1'b0;
         ready_arb_D       <= 1'b0;
         rd_flag_q         <= 1'b0;
         rd_tag_q          <= '0;
         rd_idx_q          <= '0;
      end else begin
         state_q           <= state_d;
         read_arb_L2       <= rd_d;
         write_arb_L2      <= wr_d;
         tag_arb_L2        <= tag_d;
         index_arb_L2      <= idx_d;
         write_data_arb_L2 <= wdata_d;
         ready_arb_I       <= rdy_i_d;
         ready_arb_D       <= rdy_d_d;
         rd_flag_q         <= rd_flag_d;
         rd_tag_q          <= rd_tag_d;
         rd_idx_q          <= rd_idx_d;
      end
   end

endmodule
